antirrebote_multi: RTL and testbench
====================================

Name: antirrebote_multi

Overview:
- Multi-channel, parametrised debouncer for mechanical buttons/switches feeding the pulse-counter datapath.
- Each channel: 2-flop synchroniser, then a per-channel stability counter and 4-state FSM.
- Output changes level only after the synchronised input has held the new level for STABLE_CYCLES consecutive samples.
- Optionally produces one-cycle rise/fall pulses so downstream counters need no edge detector.

Parameters:
- CHANNELS, 4: number of independent input channels (>=1).
- CNT_W, 8: stability counter width; STABLE_CYCLES must be <= 2^CNT_W.
- STABLE_CYCLES, 8: consecutive identical samples required to accept a new level (>=1).
- INIT_LEVEL, 0: level loaded into synchronisers and Data_OUT at reset, same for all channels.

Ports:
- Clk  in  1  single clock; all state updates on falling edge.
- Reset  in  1  asynchronous, active-high reset.
- Data_IN  in  CHANNELS  raw asynchronous inputs, bit i = channel i.
- Data_OUT  out  CHANNELS  debounced levels.
- Rise  out  CHANNELS  one-cycle pulse when Data_OUT[i] goes 0->1 (see Optional Feature).
- Fall  out  CHANNELS  one-cycle pulse when Data_OUT[i] goes 1->0 (see Optional Feature).

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset (async assert, any time including mid-count):
  - sync stages and Data_OUT = {CHANNELS{INIT_LEVEL}};
  - counters = 0; Rise = Fall = 0;
  - FSM = STABLE_LO if INIT_LEVEL = 0, else STABLE_HI.
- Reset deassertion takes effect at the next falling edge.
- Synchroniser: s1 <= Data_IN[i]; s2 <= s1. The FSM sees only s2.
- FSM states per channel: STABLE_LO, CHK_HI, STABLE_HI, CHK_LO.
  - STABLE_LO: s2 = 1 -> CHK_HI, cnt = 1. If STABLE_CYCLES = 1, go directly to STABLE_HI and set Data_OUT = 1.
  - CHK_HI, s2 = 1, cnt = STABLE_CYCLES-1 -> STABLE_HI, Data_OUT <= 1, cnt <= 0.
  - CHK_HI, s2 = 1, otherwise -> cnt <= cnt+1.
  - CHK_HI, s2 = 0 -> STABLE_LO, cnt <= 0. Any single glitch sample restarts qualification.
  - STABLE_HI and CHK_LO: mirror images of the above.
- Data_OUT is registered; it equals 1 exactly in STABLE_HI and CHK_LO.
- Latency: an input stable from before falling edge k changes Data_OUT at edge k+1+STABLE_CYCLES (2 sync edges + STABLE_CYCLES qualifying samples, the first overlapping the second sync edge).
- Counter saturation: cnt never exceeds STABLE_CYCLES-1 and never wraps.
- Channels are fully independent. Simultaneous transitions on several channels are each handled in the same cycle.
- Input pulse shorter than STABLE_CYCLES samples: no output change, no Rise/Fall.

Optional Feature:
- Macro: ANTIRREBOTE_EDGE_EN.
- Defined:
  - Rise[i] = 1 for exactly the one cycle following the edge where Data_OUT[i] becomes 1.
  - Fall[i] = 1 likewise when Data_OUT[i] becomes 0.
  - Both are registered, cleared by Reset, and never asserted together.
- Not defined: Rise and Fall are tied to constant 0; no edge registers are synthesised; ports remain present.

Test Plan:
- Reset check: INIT_LEVEL=0, Reset pulsed mid-simulation asynchronously between clock edges -> Data_OUT, Rise and Fall are 0 immediately, without waiting for a clock edge.
- Clean press: STABLE_CYCLES=8, Data_IN[0] 0->1 before edge k and held -> Data_OUT[0]=1 from edge k+9. With ANTIRREBOTE_EDGE_EN, Rise[0]=1 for exactly one cycle.
- Bounce: Data_IN[1] toggles with runs of 3,5,7 cycles, then holds 1 -> Data_OUT[1] stays 0 through the bounce and rises 9 edges after the final stable edge.
- Glitch rejection: Data_OUT[2]=1, then Data_IN[2]=0 for 7 cycles, then back to 1 -> Data_OUT[2] stays 1, Fall[2] never asserts.
- Independence: Data_IN=4'b1010 at the same edge -> channels 1 and 3 rise on the same edge, channels 0 and 2 stay 0.
- Reset mid-count: Reset asserted while channel 0 is in CHK_HI with cnt=5 -> after release, with input held 1, full STABLE_CYCLES re-qualification is required (rise at release edge +9).

Source files
------------

// File: rtl/antirrebote_multi_if.sv
// -----------------------------------------------------------------------------
// antirrebote_multi_if
// Groups the signals of the multi-channel debouncer. Bit i of each vector
// belongs to channel i.
//
// Signals:
//   Data_IN   raw asynchronous button/switch levels
//   Data_OUT  debounced levels
//   Rise      one-cycle pulse when Data_OUT[i] goes 0->1 (zero when edge
//             pulses are not built)
//   Fall      one-cycle pulse when Data_OUT[i] goes 1->0 (zero when edge
//             pulses are not built)
//
// Modports:
//   master  the side that owns the raw inputs and consumes the results
//   slave   the debouncer itself
// -----------------------------------------------------------------------------
interface antirrebote_multi_if #(
  parameter int CHANNELS = 4
);
  logic [CHANNELS-1:0] Data_IN;
  logic [CHANNELS-1:0] Data_OUT;
  logic [CHANNELS-1:0] Rise;
  logic [CHANNELS-1:0] Fall;

  modport master (
    output Data_IN,
    input  Data_OUT,
    input  Rise,
    input  Fall
  );

  modport slave (
    input  Data_IN,
    output Data_OUT,
    output Rise,
    output Fall
  );
endinterface

// File: rtl/antirrebote_multi.sv
// -----------------------------------------------------------------------------
// antirrebote_multi
// Multi-channel debouncer for mechanical buttons and switches. Each channel
// passes its raw input through a 2-flop synchroniser and then through a
// 4-state qualification FSM with a stability counter. The debounced level
// only changes after the synchronised input has shown the new level for
// STABLE_CYCLES consecutive samples; any sample of the old level restarts
// the qualification.
//
// All state is updated on the falling edge of Clk. Reset is asynchronous and
// active-high; its release takes effect at the next falling edge.
//
// Ports:
//   Clk    single clock, falling-edge active
//   Reset  asynchronous active-high reset
//   bus    antirrebote_multi_if.slave
//            Data_IN  (in)  raw inputs, bit i = channel i
//            Data_OUT (out) registered debounced levels
//            Rise     (out) one-cycle 0->1 pulse per channel
//            Fall     (out) one-cycle 1->0 pulse per channel
//
// Parameters:
//   CHANNELS       number of independent channels (>= 1)
//   CNT_W          stability counter width (STABLE_CYCLES <= 2**CNT_W)
//   STABLE_CYCLES  consecutive identical samples needed to accept a level
//   INIT_LEVEL     level of synchronisers and Data_OUT after reset
//
// Build option:
//   ANTIRREBOTE_EDGE_EN  when defined, Rise/Fall are registered edge pulses;
//                        otherwise they are tied to 0 and no edge registers
//                        exist.
// -----------------------------------------------------------------------------
module antirrebote_multi #(
  parameter int CHANNELS      = 4,
  parameter int CNT_W         = 8,
  parameter int STABLE_CYCLES = 8,
  parameter int INIT_LEVEL    = 0
) (
  input logic                 Clk,
  input logic                 Reset,
  antirrebote_multi_if.slave  bus
);

  // Encoding keeps the output level in the MSB's meaning: the two "high"
  // states are STABLE_HI and CHK_LO.
  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    CHK_HI    = 2'd1,
    STABLE_HI = 2'd2,
    CHK_LO    = 2'd3
  } state_e;

  localparam logic             INIT_BIT   = (INIT_LEVEL != 0);
  localparam state_e           INIT_STATE = (INIT_LEVEL != 0) ? STABLE_HI : STABLE_LO;
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  // Last count value before a level is accepted; the counter never passes it.
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(STABLE_CYCLES - 1);

  // Elaboration-time parameter sanity checks.
  if (CHANNELS < 1) begin : g_chk_channels
    $error("antirrebote_multi: CHANNELS must be >= 1");
  end
  if (CNT_W < 1) begin : g_chk_cnt_w
    $error("antirrebote_multi: CNT_W must be >= 1");
  end
  if (STABLE_CYCLES < 1) begin : g_chk_stable_min
    $error("antirrebote_multi: STABLE_CYCLES must be >= 1");
  end
  if (longint'(STABLE_CYCLES) > (64'd1 << CNT_W)) begin : g_chk_stable_max
    $error("antirrebote_multi: STABLE_CYCLES must be <= 2**CNT_W");
  end

  // ---------------------------------------------------------------------------
  // Synchroniser: two flops per channel, reset to the initial level so the
  // FSM does not see a spurious transition right after reset.
  // ---------------------------------------------------------------------------
  logic [CHANNELS-1:0] sync1_q;
  logic [CHANNELS-1:0] sync2_q;

  always_ff @(negedge Clk or posedge Reset) begin
    if (Reset) begin
      sync1_q <= {CHANNELS{INIT_BIT}};
      sync2_q <= {CHANNELS{INIT_BIT}};
    end else begin
      sync1_q <= bus.Data_IN;
      sync2_q <= sync1_q;
    end
  end

  // Debounced level, current and next, gathered from the channel FSMs.
  logic [CHANNELS-1:0] data_out_q;
  logic [CHANNELS-1:0] data_out_d;

  // ---------------------------------------------------------------------------
  // Per-channel qualification FSM and stability counter.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             dout_q;
    logic             dout_d;
    logic             s2;

    assign s2 = sync2_q[gi];

    // State register (also holds the registered output level).
    always_ff @(negedge Clk or posedge Reset) begin
      if (Reset) begin
        state_q <= INIT_STATE;
        cnt_q   <= '0;
        dout_q  <= INIT_BIT;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        dout_q  <= dout_d;
      end
    end

    // Next-state logic. The first sample of a new level is already counted
    // when entering a CHK state, so the level is accepted on the sample
    // where the counter has reached STABLE_CYCLES-1.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
        STABLE_LO: begin
          if (s2) begin
            if (STABLE_CYCLES == 1) begin
              state_d = STABLE_HI;
              cnt_d   = '0;
            end else begin
              state_d = CHK_HI;
              cnt_d   = CNT_ONE;
            end
          end
        end
        CHK_HI: begin
          if (!s2) begin
            // One sample of the old level throws away the qualification.
            state_d = STABLE_LO;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = STABLE_HI;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        STABLE_HI: begin
          if (!s2) begin
            if (STABLE_CYCLES == 1) begin
              state_d = STABLE_LO;
              cnt_d   = '0;
            end else begin
              state_d = CHK_LO;
              cnt_d   = CNT_ONE;
            end
          end
        end
        CHK_LO: begin
          if (s2) begin
            state_d = STABLE_HI;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = STABLE_LO;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      endcase
    end

    // Output logic: the debounced level is high in STABLE_HI and while a
    // fall is still being qualified (CHK_LO).
    always_comb begin
      dout_d = 1'b0;
      if ((state_d == STABLE_HI) || (state_d == CHK_LO)) begin
        dout_d = 1'b1;
      end
    end

    assign data_out_q[gi] = dout_q;
    assign data_out_d[gi] = dout_d;
  end

  assign bus.Data_OUT = data_out_q;

  // ---------------------------------------------------------------------------
  // Edge pulses: registered together with Data_OUT, so Rise/Fall are high in
  // exactly the cycle that follows the edge at which Data_OUT changed. A
  // channel can only change in one direction per edge, so they never overlap.
  // ---------------------------------------------------------------------------
`ifdef ANTIRREBOTE_EDGE_EN
  logic [CHANNELS-1:0] rise_d;
  logic [CHANNELS-1:0] fall_d;
  logic [CHANNELS-1:0] rise_q;
  logic [CHANNELS-1:0] fall_q;

  assign rise_d =  data_out_d & ~data_out_q;
  assign fall_d = ~data_out_d &  data_out_q;

  always_ff @(negedge Clk or posedge Reset) begin
    if (Reset) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign bus.Rise = rise_q;
  assign bus.Fall = fall_q;
`else
  assign bus.Rise = '0;
  assign bus.Fall = '0;
`endif

endmodule

// File: tb/tb_antirrebote_multi.sv
// -----------------------------------------------------------------------------
// tb_antirrebote_multi
// Directed bench for antirrebote_multi (CHANNELS=4, STABLE_CYCLES=8,
// INIT_LEVEL=0). Stimulus pushes the expected output changes (falling-edge
// index plus the full Data_OUT/Rise/Fall value) into a queue; an independent
// monitor samples the outputs on the rising edge and pops/compares an entry
// every time the outputs change. With STABLE_CYCLES=8 an input applied before
// falling edge k changes Data_OUT at edge k+9.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_antirrebote_multi;

  localparam int CH  = 4;
  localparam int LAT = 9;   // 1 + STABLE_CYCLES for STABLE_CYCLES = 8

  typedef struct {
    int         edge_idx;
    logic [3:0] dout;
    logic [3:0] rise;
    logic [3:0] fall;
  } ev_t;

  logic Clk = 1'b0;
  logic Reset;

  antirrebote_multi_if #(.CHANNELS(CH)) bus ();

  antirrebote_multi #(
    .CHANNELS      (CH),
    .CNT_W         (8),
    .STABLE_CYCLES (8),
    .INIT_LEVEL    (0)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  int edge_n = 0;
  always @(negedge Clk) edge_n <= edge_n + 1;

  ev_t        exp_q[$];
  int         n_checks  = 0;
  int         n_fail    = 0;
  logic       mon_en    = 1'b0;
  logic [11:0] prev_v;
  logic [3:0] exp_level = 4'b0000;

  // Monitor: sampled on the rising edge, away from the active falling edge.
  always @(posedge Clk) begin : monitor
    logic [11:0] cur;
    ev_t         ev;
    cur = {bus.Data_OUT, bus.Rise, bus.Fall};
    if (mon_en && (cur !== prev_v)) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_change at edge %0d: got out=%b rise=%b fall=%b, required no change",
                 edge_n, cur[11:8], cur[7:4], cur[3:0]);
      end else begin
        ev = exp_q.pop_front();
        if ((ev.edge_idx != edge_n) || (cur !== {ev.dout, ev.rise, ev.fall})) begin
          n_fail++;
          $display("FAIL output_event: got edge %0d out=%b rise=%b fall=%b, required edge %0d out=%b rise=%b fall=%b",
                   edge_n, cur[11:8], cur[7:4], cur[3:0],
                   ev.edge_idx, ev.dout, ev.rise, ev.fall);
        end
      end
    end
    prev_v = cur;
  end

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] req);
    n_checks++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %b, required %b", name, got, req);
    end
  endtask

  // Queue the output change(s) caused by Data_OUT becoming lvl at edge k.
  task automatic expect_level(input int k, input logic [3:0] lvl);
    ev_t        ev;
    logic [3:0] r;
    logic [3:0] f;
`ifdef ANTIRREBOTE_EDGE_EN
    r = lvl & ~exp_level;
    f = ~lvl & exp_level;
`else
    r = 4'b0000;
    f = 4'b0000;
`endif
    ev.edge_idx = k;
    ev.dout     = lvl;
    ev.rise     = r;
    ev.fall     = f;
    exp_q.push_back(ev);
    if ((r | f) != 4'b0000) begin
      ev.edge_idx = k + 1;
      ev.rise     = 4'b0000;
      ev.fall     = 4'b0000;
      exp_q.push_back(ev);
    end
    exp_level = lvl;
  endtask

  // Called just after a rising edge: the next falling edge is edge_n+1.
  task automatic step_hold(input logic [3:0] v, input int n);
    bus.Data_IN = v;
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic step_expect(input logic [3:0] v, input logic [3:0] lvl);
    int k;
    k = edge_n + 1;
    bus.Data_IN = v;
    expect_level(k + LAT, lvl);
    repeat (14) @(posedge Clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required end of stimulus");
    $fatal(1, "timeout");
  end

  initial begin
    int r;
    bus.Data_IN = 4'b0000;
    Reset       = 1'b0;

    // Power-on reset
    #1 Reset = 1'b1;
    #1;
    check("por_data_out", bus.Data_OUT, 4'b0000);
    check("por_rise",     bus.Rise,     4'b0000);
    check("por_fall",     bus.Fall,     4'b0000);
    @(negedge Clk);
    #2 Reset = 1'b0;
    repeat (3) @(posedge Clk);
    #1 mon_en = 1'b1;

    // Clean press and release on channel 0
    step_expect(4'b0001, 4'b0001);
    step_expect(4'b0000, 4'b0000);

    // Bounce on channel 1: runs of 3,5,7, a short low run, then hold high
    step_hold(4'b0010, 3);
    step_hold(4'b0000, 5);
    step_hold(4'b0010, 7);
    check("bounce_still_low", bus.Data_OUT, 4'b0000);
    step_hold(4'b0000, 3);
    step_expect(4'b0010, 4'b0010);

    // Glitch rejection on channel 2: 7-cycle low glitch while high
    step_expect(4'b0110, 4'b0110);
    step_hold(4'b0010, 7);
    step_hold(4'b0110, 14);
    check("glitch_level_kept", bus.Data_OUT, 4'b0110);
    check("glitch_no_fall",    bus.Fall,     4'b0000);

    // Channels 1 and 2 released together
    step_expect(4'b0000, 4'b0000);

    // Independence: channels 1 and 3 rise on the same edge
    step_expect(4'b1010, 4'b1010);
    step_expect(4'b0000, 4'b0000);

    // Reset while channel 0 is mid-qualification (cnt=5), channel 3 high
    step_expect(4'b1000, 4'b1000);
    bus.Data_IN = 4'b1001;
    repeat (7) @(negedge Clk);        // edges k..k+6: ch0 counter at 5
    #2;
    mon_en = 1'b0;
    Reset  = 1'b1;
    #1;
    check("midreset_data_out", bus.Data_OUT, 4'b0000);
    check("midreset_rise",     bus.Rise,     4'b0000);
    check("midreset_fall",     bus.Fall,     4'b0000);
    #1 Reset = 1'b0;
    r = edge_n + 1;                   // first edge after release
    exp_level = 4'b0000;
    expect_level(r + LAT, 4'b1001);
    @(posedge Clk);
    #1 mon_en = 1'b1;
    repeat (14) @(posedge Clk);
    #1;
    check("requal_level", bus.Data_OUT, 4'b1001);

    // Every queued output change must have been observed
    repeat (4) @(posedge Clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL pending_events: got %0d unobserved, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
